dma_desc_scheduler: RTL and testbench

DMA_DESC_SCHEDULER -- requirements
Module: dma_desc_scheduler

---
 rtl/dma_desc_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_dma_desc_scheduler.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_scheduler.sv
// DMA descriptor scheduler: queues {last,src,dst,len} descriptors and
// splits each one into bursts of at most MAX_BURST bytes. Only one burst is
// outstanding at a time. When a scatter list completes, or a burst fails,
// a level interrupt is raised.
// Optional feature: define DMA_SCHED_4K_SPLIT_EN to keep every burst inside
// a single 4 KB page on both the source and the destination side.
module dma_desc_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        desc_push_i,
    input  logic        desc_last_i,
    input  logic [31:0] desc_src_i,
    input  logic [31:0] desc_dst_i,
    input  logic [31:0] desc_len_i,
    output logic        fifo_full_o,
    output logic        brst_valid_o,
    input  logic        brst_ready_i,
    output logic [31:0] brst_src_o,
    output logic [31:0] brst_dst_o,
    output logic [6:0]  brst_bytes_o,
    input  logic        brst_done_i,
    input  logic        brst_err_i,
    output logic        busy_o,
    output logic        irq_o,
    output logic        irq_err_o,
    output logic [31:0] err_addr_o,
    input  logic        irq_clr_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_ERR} state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_t;

    desc_t             fifo_mem [FIFO_DEPTH];
    desc_t             head;
    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [31:0]       cur_rem_q, cur_rem_d;
    logic              cur_last_q, cur_last_d;
    logic [31:0]       burst_src_q, burst_src_d;
    logic              irq_q, irq_d, irq_err_q, irq_err_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [31:0]       bytes_w;
    logic              push_ok, pop, flush, irq_set, err_set;

    assign head         = fifo_mem[rd_ptr_q];
    assign fifo_full_o  = (count_q == CW'(FIFO_DEPTH));
    // A failed burst empties the queue; the same-cycle push is discarded with it.
    assign flush        = (state_q == S_WAIT) && brst_done_i && brst_err_i;
    assign pop          = (state_q == S_LOAD);
    assign push_ok      = desc_push_i && !fifo_full_o && (state_q != S_ERR) && !flush;
    assign brst_valid_o = (state_q == S_ISSUE);
    assign brst_src_o   = cur_src_q;
    assign brst_dst_o   = cur_dst_q;
    assign brst_bytes_o = bytes_w[6:0];
    assign busy_o       = (state_q != S_IDLE) || (count_q != '0);
    assign irq_o        = irq_q;
    assign irq_err_o    = irq_err_q;
    assign err_addr_o   = err_addr_q;

    // Burst size: remaining bytes capped at MAX_BURST (and at page ends if enabled).
`ifdef DMA_SCHED_4K_SPLIT_EN
    logic [31:0] src_room, dst_room;
`endif
    always_comb begin
        bytes_w = (cur_rem_q < 32'(MAX_BURST)) ? cur_rem_q : 32'(MAX_BURST);
`ifdef DMA_SCHED_4K_SPLIT_EN
        src_room = 32'd4096 - {20'd0, cur_src_q[11:0]};
        dst_room = 32'd4096 - {20'd0, cur_dst_q[11:0]};
        if (src_room < bytes_w) bytes_w = src_room;
        if (dst_room < bytes_w) bytes_w = dst_room;
`endif
    end

    // Descriptor storage; contents need no reset because count_q gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= '{desc_last_i, desc_src_i, desc_dst_i, desc_len_i};
    end

    // Queue pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop);
        end
    end

    // FSM next state, current-descriptor tracking and interrupt events.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        cur_rem_d   = cur_rem_q;
        cur_last_d  = cur_last_q;
        burst_src_d = burst_src_q;
        err_addr_d  = err_addr_q;
        irq_set     = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A pending interrupt holds off the next descriptor.
                if (count_q != '0 && !irq_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                cur_src_d  = head.src;
                cur_dst_d  = head.dst;
                cur_rem_d  = head.len;
                cur_last_d = head.last;
                if (head.len == '0) begin
                    irq_set = head.last;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (brst_ready_i) begin
                    burst_src_d = cur_src_q;
                    cur_src_d   = cur_src_q + bytes_w;
                    cur_dst_d   = cur_dst_q + bytes_w;
                    cur_rem_d   = cur_rem_q - bytes_w;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (brst_done_i) begin
                    if (brst_err_i) begin
                        err_addr_d = burst_src_q;
                        err_set    = 1'b1;
                        state_d    = S_ERR;
                    end else if (cur_rem_q != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        irq_set = cur_last_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                if (irq_clr_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Acknowledge first so that a coinciding new event overrides it.
        irq_d     = irq_q;
        irq_err_d = irq_err_q;
        if (irq_clr_i) begin
            irq_d     = 1'b0;
            irq_err_d = 1'b0;
        end
        if (irq_set) begin
            irq_d     = 1'b1;
            irq_err_d = 1'b0;
        end
        if (err_set) begin
            irq_d     = 1'b1;
            irq_err_d = 1'b1;
        end
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            cur_rem_q   <= '0;
            cur_last_q  <= 1'b0;
            burst_src_q <= '0;
            irq_q       <= 1'b0;
            irq_err_q   <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            cur_rem_q   <= cur_rem_d;
            cur_last_q  <= cur_last_d;
            burst_src_q <= burst_src_d;
            irq_q       <= irq_d;
            irq_err_q   <= irq_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Testbench for dma_desc_scheduler: scenario tasks plus a randomized run
// checked against a descriptor-to-burst reference model.
module tb_dma_desc_scheduler;
    localparam int FIFO_DEPTH = 4;
    localparam int MAXB       = 64;

    typedef struct packed {
        logic        last;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [6:0]  bytes;
    } burst_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        desc_push_i = 1'b0, desc_last_i = 1'b0;
    logic [31:0] desc_src_i = '0, desc_dst_i = '0, desc_len_i = '0;
    logic        fifo_full_o, brst_valid_o, busy_o, irq_o, irq_err_o;
    logic        brst_ready_i = 1'b0, brst_done_i = 1'b0, brst_err_i = 1'b0, irq_clr_i = 1'b0;
    logic [31:0] brst_src_o, brst_dst_o, err_addr_o;
    logic [6:0]  brst_bytes_o;

    int n_cmp = 0;
    int n_fail = 0;

    burst_t got_q[$], exp_q[$];
    logic   got_irq[$], exp_irq[$];
    desc_t  pend_q[$];

    int eng_ready_pct, eng_dly_max, eng_err_at, eng_dly, eng_idx, eng_acc;
    bit eng_auto_clr, eng_auto_push, eng_out;

    dma_desc_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rstn(rstn),
        .desc_push_i(desc_push_i), .desc_last_i(desc_last_i),
        .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i), .desc_len_i(desc_len_i),
        .fifo_full_o(fifo_full_o), .brst_valid_o(brst_valid_o), .brst_ready_i(brst_ready_i),
        .brst_src_o(brst_src_o), .brst_dst_o(brst_dst_o), .brst_bytes_o(brst_bytes_o),
        .brst_done_i(brst_done_i), .brst_err_i(brst_err_i), .busy_o(busy_o),
        .irq_o(irq_o), .irq_err_o(irq_err_o), .err_addr_o(err_addr_o), .irq_clr_i(irq_clr_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: chop a descriptor into bursts from the sizing rules.
    task automatic model_add(input desc_t d);
        logic [31:0] s, t, r;
        int unsigned b, room;
        s = d.src; t = d.dst; r = d.len;
        while (r != 0) begin
            b = (r > MAXB) ? MAXB : r;
`ifdef DMA_SCHED_4K_SPLIT_EN
            room = 4096 - (s % 4096);
            if (room < b) b = room;
            room = 4096 - (t % 4096);
            if (room < b) b = room;
`else
            room = 0;
`endif
            exp_q.push_back('{src: s, dst: t, bytes: 7'(b)});
            s = s + b; t = t + b; r = r - b;
        end
        if (d.last) exp_irq.push_back(1'b0);
    endtask

    task automatic eng_reset();
        got_q.delete(); exp_q.delete(); got_irq.delete(); exp_irq.delete(); pend_q.delete();
        eng_ready_pct = 100; eng_dly_max = 0; eng_err_at = -1;
        eng_auto_clr = 0; eng_auto_push = 1; eng_out = 0; eng_dly = 0; eng_idx = 0; eng_acc = 0;
    endtask

    // One cycle of a well-behaved CSR/datapath environment; records what it sees.
    task automatic cyc();
        desc_push_i = 0; brst_done_i = 0; brst_err_i = 0; irq_clr_i = 0;
        if (eng_auto_push && pend_q.size() != 0 && !fifo_full_o) begin
            desc_t d;
            d = pend_q.pop_front();
            desc_push_i = 1; desc_last_i = d.last;
            desc_src_i = d.src; desc_dst_i = d.dst; desc_len_i = d.len;
            model_add(d);
        end
        if (eng_out) begin
            if (eng_dly == 0) begin
                brst_done_i = 1;
                brst_err_i  = (eng_idx == eng_err_at);
                eng_out     = 0;
            end else begin
                eng_dly--;
            end
        end
        brst_ready_i = ($urandom_range(99) < eng_ready_pct);
        if (brst_valid_o && brst_ready_i) begin
            got_q.push_back('{src: brst_src_o, dst: brst_dst_o, bytes: brst_bytes_o});
            eng_out = 1;
            eng_dly = $urandom_range(eng_dly_max);
            eng_idx = eng_acc;
            eng_acc++;
        end
        if (eng_auto_clr && irq_o) begin
            got_irq.push_back(irq_err_o);
            irq_clr_i = 1;
        end
        tick();
    endtask

    task automatic push_desc(input desc_t d);
        desc_push_i = 1; desc_last_i = d.last;
        desc_src_i = d.src; desc_dst_i = d.dst; desc_len_i = d.len;
        tick();
        desc_push_i = 0;
    endtask

    task automatic clear_irq();
        irq_clr_i = 1;
        tick();
        irq_clr_i = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) tick();
        n_cmp++;
        if ({brst_valid_o, fifo_full_o, busy_o, irq_o, irq_err_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {brst_valid_o, fifo_full_o, busy_o, irq_o, irq_err_o});
        end
        n_cmp++;
        if ({brst_src_o, brst_dst_o, brst_bytes_o, err_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: src %h dst %h bytes %0d err_addr %h want all 0",
                     brst_src_o, brst_dst_o, brst_bytes_o, err_addr_o);
        end
        rstn = 1;
        tick();
    endtask

    task automatic test_basic();
        eng_reset();
        pend_q.push_back('{last: 1'b1, src: 32'h1000, dst: 32'h2000, len: 32'd150});
        for (int c = 0; c < 200 && !irq_o; c++) cyc();
        n_cmp++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d bursts want 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_burst%0d: got %h/%h/%0d want %h/%h/%0d", i,
                         got_q[i].src, got_q[i].dst, got_q[i].bytes, exp_q[i].src, exp_q[i].dst, exp_q[i].bytes);
            end
        end
        n_cmp++;
        if ({irq_o, irq_err_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_irq: got irq %b err %b want 1 0", irq_o, irq_err_o);
        end
        clear_irq();
        n_cmp++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_irq_clr: got irq %b want 0", irq_o);
        end
    endtask

    task automatic test_zero_len();
        logic seen_valid;
        logic [2:0] irq_hist;
        seen_valid = 0;
        push_desc('{last: 1'b1, src: 32'h4000, dst: 32'h5000, len: 32'd0});
        irq_hist[0] = irq_o; seen_valid |= brst_valid_o;
        tick();
        irq_hist[1] = irq_o; seen_valid |= brst_valid_o;
        tick();
        irq_hist[2] = irq_o; seen_valid |= brst_valid_o;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_valid |= brst_valid_o;
        end
        n_cmp++;
        if (irq_hist !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_len_irq_timing: got %b (edges 2..0) want 100", irq_hist);
        end
        n_cmp++;
        if (seen_valid !== 1'b0 || irq_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_no_burst: valid seen %b irq_err %b want 0 0", seen_valid, irq_err_o);
        end
        clear_irq();
    endtask

    task automatic test_fifo_full();
        desc_t d;
        eng_reset();
        brst_ready_i = 0;
        d = '{last: 1'b0, src: 32'hA000, dst: 32'hB000, len: 32'd8};
        push_desc(d);
        model_add(d);
        n_cmp++;
        if (brst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL latency_edge1: valid %b want 0", brst_valid_o);
        end
        tick();
        n_cmp++;
        if (brst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL latency_edge2: valid %b want 0", brst_valid_o);
        end
        tick();
        n_cmp++;
        if (brst_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL latency_edge3: valid %b want 1", brst_valid_o);
        end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (brst_valid_o !== 1'b1 || brst_src_o !== 32'hA000 || brst_dst_o !== 32'hB000 || brst_bytes_o !== 7'd8) begin
                n_fail++;
                $display("FAIL hold_stable%0d: valid %b %h/%h/%0d want 1 a000/b000/8",
                         c, brst_valid_o, brst_src_o, brst_dst_o, brst_bytes_o);
            end
            tick();
        end
        for (int k = 1; k <= 5; k++) begin
            d = '{last: 1'b0, src: 32'h10000 * k, dst: 32'h20000 * k, len: 32'd8};
            push_desc(d);
            if (k <= 4) model_add(d);
            n_cmp++;
            if (fifo_full_o !== (k >= 4)) begin
                n_fail++;
                $display("FAIL fifo_full_after_push%0d: got %b want %b", k, fifo_full_o, (k >= 4));
            end
        end
        eng_auto_push = 0;
        for (int c = 0; c < 300 && busy_o; c++) cyc();
        n_cmp++;
        if (got_q.size() != 5) begin
            n_fail++;
            $display("FAIL fifo_exec_count: got %0d bursts want 5", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fifo_burst%0d: got src %h want %h", i, got_q[i].src, exp_q[i].src);
            end
        end
    endtask

    task automatic test_error();
        logic seen_valid;
        eng_reset();
        eng_err_at = 1;
        pend_q.push_back('{last: 1'b0, src: 32'h1000, dst: 32'h5000, len: 32'd150});
        pend_q.push_back('{last: 1'b0, src: 32'h7000, dst: 32'h8000, len: 32'd20});
        pend_q.push_back('{last: 1'b1, src: 32'h9000, dst: 32'hC000, len: 32'd30});
        for (int c = 0; c < 200 && !irq_o; c++) cyc();
        brst_ready_i = 1;
        n_cmp++;
        if ({irq_o, irq_err_o} !== 2'b11 || err_addr_o !== 32'h1040) begin
            n_fail++;
            $display("FAIL error_capture: irq %b err %b addr %h want 1 1 00001040", irq_o, irq_err_o, err_addr_o);
        end
        n_cmp++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL error_burst_count: got %0d want 2", got_q.size());
        end
        seen_valid = 0;
        push_desc('{last: 1'b1, src: 32'hD000, dst: 32'hE000, len: 32'd4});
        for (int c = 0; c < 10; c++) begin
            seen_valid |= brst_valid_o;
            tick();
        end
        n_cmp++;
        if (seen_valid !== 1'b0 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL error_hold: valid seen %b irq %b want 0 1", seen_valid, irq_o);
        end
        clear_irq();
        n_cmp++;
        if ({irq_o, irq_err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL error_clr: irq %b err %b want 0 0", irq_o, irq_err_o);
        end
        tick(); tick();
        n_cmp++;
        if ({busy_o, brst_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL error_flushed: busy %b valid %b want 0 0", busy_o, brst_valid_o);
        end
    endtask

    task automatic test_split();
        eng_reset();
        pend_q.push_back('{last: 1'b1, src: 32'h0FF0, dst: 32'h3000, len: 32'd64});
        for (int c = 0; c < 200 && !irq_o; c++) cyc();
        n_cmp++;
`ifdef DMA_SCHED_4K_SPLIT_EN
        if (got_q.size() != 2 || got_q[0].bytes !== 7'd16 || got_q[1].bytes !== 7'd48) begin
            n_fail++;
            $display("FAIL split_sizes: got %0d bursts want 16 then 48", got_q.size());
        end
`else
        if (got_q.size() != 1 || got_q[0].bytes !== 7'd64) begin
            n_fail++;
            $display("FAIL split_sizes: got %0d bursts want one of 64", got_q.size());
        end
`endif
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL split_burst%0d: got %h/%h/%0d want %h/%h/%0d", i,
                         got_q[i].src, got_q[i].dst, got_q[i].bytes, exp_q[i].src, exp_q[i].dst, exp_q[i].bytes);
            end
        end
        clear_irq();
    endtask

    task automatic test_random();
        bit fin;
        eng_reset();
        eng_ready_pct = 60; eng_dly_max = 3; eng_auto_clr = 1;
        pend_q.push_back('{last: 1'b1, src: 32'hFFFF_FFF0, dst: 32'h0000_0FE0, len: 32'd100});
        for (int i = 0; i < 40; i++) begin
            desc_t d;
            d.last = ($urandom_range(3) == 0);
            d.src  = $urandom;
            d.dst  = $urandom;
            if ($urandom_range(1)) d.src[11:0] = 12'hFFF - 12'($urandom_range(70));
            if ($urandom_range(1)) d.dst[11:0] = 12'hFFF - 12'($urandom_range(70));
            d.len  = ($urandom_range(5) == 0) ? 32'd0 : 32'($urandom_range(300));
            pend_q.push_back(d);
        end
        fin = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            cyc();
            fin = (pend_q.size() == 0) && !busy_o && !irq_o && !eng_out && (got_q.size() >= exp_q.size());
        end
        n_cmp++;
        if (!fin) begin
            n_fail++;
            $display("FAIL random_timeout: got %0d of %0d bursts", got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (got_q.size() != exp_q.size() || got_irq.size() != exp_irq.size()) begin
            n_fail++;
            $display("FAIL random_counts: bursts %0d want %0d, irqs %0d want %0d",
                     got_q.size(), exp_q.size(), got_irq.size(), exp_irq.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_burst%0d: got %h/%h/%0d want %h/%h/%0d", i,
                         got_q[i].src, got_q[i].dst, got_q[i].bytes, exp_q[i].src, exp_q[i].dst, exp_q[i].bytes);
            end
        end
        for (int i = 0; i < got_irq.size() && i < exp_irq.size(); i++) begin
            n_cmp++;
            if (got_irq[i] !== exp_irq[i]) begin
                n_fail++;
                $display("FAIL random_irq%0d: irq_err %b want %b", i, got_irq[i], exp_irq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        push_desc('{last: 1'b1, src: 32'h100, dst: 32'h200, len: 32'd200});
        brst_ready_i = 1;
        tick(); tick(); tick();
        brst_ready_i = 0;
        n_cmp++;
        if ({brst_valid_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_in_wait: valid %b busy %b want 0 1", brst_valid_o, busy_o);
        end
        #2 rstn = 0;
        #1;
        n_cmp++;
        if ({brst_valid_o, fifo_full_o, busy_o, irq_o, irq_err_o} !== 5'b0 ||
            {brst_src_o, brst_dst_o, brst_bytes_o, err_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: flags %b src %h dst %h bytes %0d err_addr %h want all 0",
                     {brst_valid_o, fifo_full_o, busy_o, irq_o, irq_err_o},
                     brst_src_o, brst_dst_o, brst_bytes_o, err_addr_o);
        end
        tick(); tick();
        rstn = 1;
        tick();
        brst_done_i = 1;
        tick();
        brst_done_i = 0;
        tick(); tick();
        n_cmp++;
        if ({brst_valid_o, busy_o, irq_o, irq_err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done_ignored: valid %b busy %b irq %b err %b want 0",
                     brst_valid_o, busy_o, irq_o, irq_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_fifo_full();
        test_error();
        test_split();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
